// File: rtl/flow_pkg.sv
// Shared types, thresholds and code-conversion helpers for the flow-rate level path.
package flow_pkg;

    typedef logic [2:0] level_t;

    typedef enum logic [1:0] {
        DISABLED,
        ACQUIRE,
        TRACK,
        ALARM
    } state_t;

    localparam logic [3:0] FLOW_TH_L1 = 4'd3;
    localparam logic [3:0] FLOW_TH_L2 = 4'd4;
    localparam logic [3:0] FLOW_TH_L3 = 4'd5;
    localparam logic [3:0] FLOW_TH_L4 = 4'd6;
    localparam logic [3:0] FLOW_TH_L5 = 4'd7;

    function automatic level_t flow_to_level(input logic [3:0] code);
        level_t lvl;
        if (code >= FLOW_TH_L5)      lvl = 3'd5;
        else if (code >= FLOW_TH_L4) lvl = 3'd4;
        else if (code >= FLOW_TH_L3) lvl = 3'd3;
        else if (code >= FLOW_TH_L2) lvl = 3'd2;
        else if (code >= FLOW_TH_L1) lvl = 3'd1;
        else                         lvl = 3'd0;
        return lvl;
    endfunction

    // Levels above 5 cannot occur, but saturate the bar rather than wrap.
    function automatic logic [4:0] level_to_therm(input level_t lvl);
        logic [4:0] therm;
        case (lvl)
            3'd0:    therm = 5'b00000;
            3'd1:    therm = 5'b00001;
            3'd2:    therm = 5'b00011;
            3'd3:    therm = 5'b00111;
            3'd4:    therm = 5'b01111;
            default: therm = 5'b11111;
        endcase
        return therm;
    endfunction

endpackage

// File: rtl/flow_level_qualifier.sv
// Debounce stage: tracks the last sampled candidate level and how many
// consecutive ticks it has repeated; pulses commit_pulse once it is stable.
module flow_level_qualifier
    import flow_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       tick,
    input  logic [2:0] candidate,
    output logic       commit_pulse,
    output logic [2:0] commit_level
);

    localparam int unsigned SW = $clog2(STABLE_CNT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT);

    level_t        last_cand;
    logic [SW-1:0] stab_cnt;
    logic [SW-1:0] stab_nxt;

    always_comb begin
        stab_nxt = stab_cnt;
        if (candidate == last_cand) begin
            if (stab_cnt != STAB_MAX)
                stab_nxt = stab_cnt + 1'b1;
        end else begin
            stab_nxt = SW'(1);
        end
    end

    // commit_pulse is registered, giving the one-cycle latency after the tick edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cand    <= '0;
            stab_cnt     <= '0;
            commit_pulse <= 1'b0;
            commit_level <= '0;
        end else if (clr) begin
            last_cand    <= '0;
            stab_cnt     <= '0;
            commit_pulse <= 1'b0;
            commit_level <= '0;
        end else begin
            commit_pulse <= tick && (stab_nxt == STAB_MAX);
            if (tick) begin
                last_cand    <= candidate;
                stab_cnt     <= stab_nxt;
                commit_level <= candidate;
            end
        end
    end

endmodule

// File: rtl/flow_level_controller.sv
// Flow-rate sampling controller: prescaler, debounced level commit, bar output
// and sticky low-flow alarm. FLOW_PEAK_HOLD_EN adds peak_clr / peak_level.
module flow_level_controller
    import flow_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned LOW_LIMIT  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] flow_rate,
    input  logic       alarm_clr,
`ifdef FLOW_PEAK_HOLD_EN
    input  logic       peak_clr,
    output logic [2:0] peak_level,
`endif
    output logic [4:0] bits,
    output logic [2:0] level,
    output logic       level_valid,
    output logic       low_flow_alarm
);

    localparam int unsigned PW = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0] DIV_MAX = PW'(SAMPLE_DIV - 1);
    localparam int unsigned LW = $clog2(LOW_LIMIT + 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(LOW_LIMIT);

    state_t        state;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [LW-1:0] low_cnt;
    logic [LW-1:0] low_nxt;
    level_t        cand;
    logic          q_clr;
    logic          commit_pulse;
    level_t        commit_level;
    logic          do_commit;

    assign cand  = flow_to_level(flow_rate);
    assign tick  = (state != DISABLED) && (pre_cnt == DIV_MAX);
    // Clearing on !enable as well makes a falling enable win over a coincident tick.
    assign q_clr = !enable || (state == DISABLED);
    assign do_commit = commit_pulse && (state != DISABLED) &&
                       (!level_valid || (commit_level != level));

    always_comb begin
        low_nxt = '0;
        if (level == '0)
            low_nxt = (low_cnt == LOW_MAX) ? low_cnt : low_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else if (q_clr || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    flow_level_qualifier #(
        .STABLE_CNT (STABLE_CNT)
    ) u_qual (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (q_clr),
        .tick         (tick),
        .candidate    (cand),
        .commit_pulse (commit_pulse),
        .commit_level (commit_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= DISABLED;
            bits           <= '0;
            level          <= '0;
            level_valid    <= 1'b0;
            low_flow_alarm <= 1'b0;
            low_cnt        <= '0;
        end else if (!enable) begin
            state          <= DISABLED;
            bits           <= '0;
            level          <= '0;
            level_valid    <= 1'b0;
            low_flow_alarm <= 1'b0;
            low_cnt        <= '0;
        end else begin
            if (do_commit) begin
                level       <= commit_level;
                bits        <= level_to_therm(commit_level);
                level_valid <= 1'b1;
            end
            case (state)
                DISABLED: state <= ACQUIRE;
                ACQUIRE: begin
                    if (do_commit)
                        state <= TRACK;
                end
                TRACK: begin
                    if (tick) begin
                        low_cnt <= low_nxt;
                        if (low_nxt == LOW_MAX) begin
                            state          <= ALARM;
                            low_flow_alarm <= 1'b1;
                        end
                    end
                end
                ALARM: begin
                    // Uses the level registered before this edge, even if a commit lands now.
                    if (alarm_clr && (level != '0)) begin
                        state          <= TRACK;
                        low_flow_alarm <= 1'b0;
                        low_cnt        <= '0;
                    end else if (tick) begin
                        low_cnt <= low_nxt;
                    end
                end
                default: state <= DISABLED;
            endcase
        end
    end

`ifdef FLOW_PEAK_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            peak_level <= '0;
        else if (!enable || (state == DISABLED))
            peak_level <= '0;
        else if (peak_clr)
            peak_level <= do_commit ? commit_level : level;
        else if (do_commit && (commit_level > peak_level))
            peak_level <= commit_level;
    end
`endif

endmodule

// File: tb/tb_flow_level_controller.sv
// Directed bench for flow_level_controller with SAMPLE_DIV=4, STABLE_CNT=3, LOW_LIMIT=2.
module tb_flow_level_controller;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] flow_rate;
    logic       alarm_clr;
    logic [4:0] bits;
    logic [2:0] level;
    logic       level_valid;
    logic       low_flow_alarm;
`ifdef FLOW_PEAK_HOLD_EN
    logic       peak_clr;
    logic [2:0] peak_level;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    flow_level_controller #(
        .SAMPLE_DIV (4),
        .STABLE_CNT (3),
        .LOW_LIMIT  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .flow_rate      (flow_rate),
        .alarm_clr      (alarm_clr),
`ifdef FLOW_PEAK_HOLD_EN
        .peak_clr       (peak_clr),
        .peak_level     (peak_level),
`endif
        .bits           (bits),
        .level          (level),
        .level_valid    (level_valid),
        .low_flow_alarm (low_flow_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // t counts rising edges since the edge that moved the DUT into ACQUIRE.
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    // Advance to the negedge just after the k-th upcoming tick edge.
    task automatic to_tick(input int k);
        int target;
        target = ((t / 4) + 1) * 4 + 4 * (k - 1);
        adv(target - t);
    endtask

    task automatic acquire(input logic [3:0] f, input logic [4:0] exp_bits,
                           input logic [2:0] exp_lvl, input string tag);
        int n;
        flow_rate = f;
        enable    = 1'b1;
        @(negedge clk);
        n = 0;
        while (!level_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd13);
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_level"}, 32'(level), 32'(exp_lvl));
        t = n;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        flow_rate = 4'd0;
        alarm_clr = 1'b0;
`ifdef FLOW_PEAK_HOLD_EN
        peak_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_bits", 32'(bits), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(level_valid), 32'd0);
        check("rst_alarm", 32'(low_flow_alarm), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", 32'(level_valid), 32'd0);

        // First acquisition at flow 5 -> level 3
        acquire(4'd5, 5'b00111, 3'd3, "acq");

        // Commit level 2, then reject a 2-tick glitch to 7
        flow_rate = 4'd4;
        to_tick(3); adv(1);
        check("lvl2_bits", 32'(bits), 32'b00011);
        flow_rate = 4'd7;
        to_tick(2);
        flow_rate = 4'd4;
        to_tick(3); adv(1);
        check("glitch_bits", 32'(bits), 32'b00011);
        flow_rate = 4'd7;
        to_tick(3); adv(1);
        check("lvl5_bits", 32'(bits), 32'b11111);
        check("lvl5_level", 32'(level), 32'd5);

        // Low-flow alarm
        flow_rate = 4'd0;
        to_tick(3); adv(1);
        check("lvl0_level", 32'(level), 32'd0);
        to_tick(1);
        check("alarm_early", 32'(low_flow_alarm), 32'd0);
        to_tick(1);
        check("alarm_set", 32'(low_flow_alarm), 32'd1);
        alarm_clr = 1'b1; adv(1); alarm_clr = 1'b0;
        check("alarm_clr_at0", 32'(low_flow_alarm), 32'd1);
        flow_rate = 4'd6;
        to_tick(3); adv(1);
        check("recover_bits", 32'(bits), 32'b01111);
        check("alarm_sticky", 32'(low_flow_alarm), 32'd1);
        alarm_clr = 1'b1; adv(1); alarm_clr = 1'b0;
        check("alarm_cleared", 32'(low_flow_alarm), 32'd0);

        // Enable dropped while in ALARM
        flow_rate = 4'd0;
        to_tick(3); adv(1);
        to_tick(2);
        check("alarm_again", 32'(low_flow_alarm), 32'd1);
        enable = 1'b0; adv(1);
        check("dis_alarm", 32'(low_flow_alarm), 32'd0);
        check("dis_bits", 32'(bits), 32'd0);
        check("dis_valid", 32'(level_valid), 32'd0);

        // Enable falling on the committing tick edge suppresses the commit
        flow_rate = 4'd5;
        enable    = 1'b1;
        @(negedge clk); t = 0;
        adv(11);
        enable = 1'b0;
        adv(2);
        check("tickfall_valid", 32'(level_valid), 32'd0);
        check("tickfall_bits", 32'(bits), 32'd0);

        acquire(4'd5, 5'b00111, 3'd3, "reacq");

        // Asynchronous reset mid-run at level 4
        flow_rate = 4'd6;
        to_tick(3); adv(1);
        check("pre_rst_level", 32'(level), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("async_bits", 32'(bits), 32'd0);
        check("async_level", 32'(level), 32'd0);
        check("async_valid", 32'(level_valid), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_bits", 32'(bits), 32'd0);
        check("post_rst_valid", 32'(level_valid), 32'd0);

`ifdef FLOW_PEAK_HOLD_EN
        acquire(4'd4, 5'b00011, 3'd2, "pk_acq");
        check("peak_2", 32'(peak_level), 32'd2);
        flow_rate = 4'd7;
        to_tick(3); adv(1);
        flow_rate = 4'd3;
        to_tick(3); adv(1);
        check("pk_level1", 32'(level), 32'd1);
        check("peak_5", 32'(peak_level), 32'd5);
        peak_clr = 1'b1; adv(1); peak_clr = 1'b0;
        check("peak_clr", 32'(peak_level), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flow_level_controller.md
Name: flow_level_controller

Overview:
Periodic sampling controller for the flow-rate bar-graph display path.
- Prescales `clk` into sample ticks and samples the 4-bit `flow_rate` sensor code on each tick.
- Debounces the sensor code into a committed level 0..5 and drives the 5-bit thermometer bar.
- Raises a sticky low-flow alarm when zero flow persists. Sits between the flow sensor interface and the front-panel LEDs/alarm logic.

Parameters:
- SAMPLE_DIV, 1000: clk cycles per sample tick (>=2).
- STABLE_CNT, 4: consecutive identical candidate levels needed to commit (>=1).
- LOW_LIMIT, 8: consecutive committed-level-0 ticks that raise the alarm (>=1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run control; 0 holds the block in DISABLED.
- flow_rate  in  4  sensor code, sampled only on tick edges.
- alarm_clr  in  1  single-cycle pulse that acknowledges the alarm.
- bits  out  5  thermometer bar for the committed level.
- level  out  3  committed level, 0..5.
- level_valid  out  1  high once the first level has been committed.
- low_flow_alarm  out  1  sticky low-flow alarm.

Behaviour:
- Reset values (rst_n=0, async): bits=5'b00000, level=0, level_valid=0, low_flow_alarm=0, state=DISABLED, all counters 0.
- Candidate level map: flow_rate<3 ->0; 3 ->1; 4 ->2; 5 ->3; 6 ->4; >=7 ->5.
- Thermometer map: bits = (1<<level)-1, saturating at 5'b11111 for level 5.
- Prescaler: counts 0..SAMPLE_DIV-1 and is held at 0 in DISABLED. Tick is high for the cycle in which the count equals SAMPLE_DIV-1; the count wraps to 0 after that cycle. The first tick falls SAMPLE_DIV cycles after entering ACQUIRE.
- Qualifier, on each tick:
  - If candidate equals last_cand: stab_cnt increments, saturating at STABLE_CNT.
  - Otherwise: last_cand <= candidate and stab_cnt <= 1.
- Commit: if stab_cnt reaches STABLE_CNT on a tick, level/bits update on the next clk edge (1-cycle latency after the tick edge).
  - Commit only if candidate != level or level_valid=0; otherwise nothing changes.
  - First valid output appears STABLE_CNT*SAMPLE_DIV+1 cycles after enable rises.
- FSM states:
  - DISABLED: outputs at reset values, counters cleared. Go to ACQUIRE when enable=1.
  - ACQUIRE: level_valid=0. Go to TRACK on the first commit; level_valid rises with that commit.
  - TRACK: level_valid=1.
    - low_cnt increments on each tick while committed level==0 and clears on any tick with level>0.
    - When low_cnt reaches LOW_LIMIT, go to ALARM and set low_flow_alarm the same edge.
  - ALARM: low_flow_alarm=1; level/bits keep tracking.
    - alarm_clr=1 with committed level>0 -> TRACK, alarm cleared, low_cnt cleared.
    - alarm_clr while level==0 is ignored.
- enable=0 in any state -> DISABLED on the next edge. Everything is cleared, including the alarm.
- Simultaneous commit and alarm_clr: the clear test uses the level value registered before that edge.
- Simultaneous tick and enable falling: enable wins, and no commit occurs.
- low_cnt saturates at LOW_LIMIT.
- flow_rate is never sampled between ticks.

Optional Feature:
FLOW_PEAK_HOLD_EN
- Defined: adds output peak_level[2:0] and input peak_clr.
  - peak_level holds the maximum committed level since reset, enable rise, or peak_clr.
  - It updates on the same edge as the commit.
  - peak_clr coincident with a commit loads the new level.
  - peak_level resets to 0.
- Undefined: neither port nor its logic exists, and the remaining behaviour is unchanged.

Decomposition:
- Shared package flow_pkg:
  - level_t (3-bit) typedef.
  - state enum {DISABLED, ACQUIRE, TRACK, ALARM}.
  - Threshold constants FLOW_TH_L1..L5 = 3,4,5,6,7.
  - Function level_to_therm.
- Sub-module flow_level_qualifier: takes the tick and candidate, owns last_cand and stab_cnt, and outputs commit_pulse and commit_level. The prescaler, FSM and alarm stay in the top level.

Test Plan:
All scenarios use SAMPLE_DIV=4, STABLE_CNT=3, LOW_LIMIT=2.
1. Reset mid-run: assert rst_n=0 with level=4 -> all outputs 0 asynchronously; after release, outputs stay 0 until enable.
2. enable=1 with flow_rate held at 5 -> bits=5'b00111, level=3, level_valid=1 exactly 13 cycles after enable; no earlier change.
3. Glitch rejection: level committed at 2; flow_rate=7 for 2 ticks, then back to 4 -> bits stays 5'b00011. Then hold 7 for 3 ticks -> bits=5'b11111.
4. flow_rate=0 until committed level 0, then 2 more ticks -> low_flow_alarm=1. alarm_clr while still at level 0 -> alarm stays 1. Raise flow to 6, wait for commit (bits=5'b01111), pulse alarm_clr -> alarm=0.
5. enable dropped in ALARM -> next edge: alarm=0, bits=0, level_valid=0. Re-enable -> the 13-cycle acquire latency repeats.
6. With FLOW_PEAK_HOLD_EN defined: commit levels 2, then 5, then 1 -> peak_level=5; pulse peak_clr -> peak_level loads the current level 1.
